// File: rtl/pipe_adder.sv
// pipe_adder: pipelined chunked ripple-carry adder with valid/ready handshake; define PIPE_ADDER_OVF_EN for the OVF output
module pipe_adder #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CIN,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] SUM,
    output logic             COUT
`ifdef PIPE_ADDER_OVF_EN
    ,
    output logic             OVF
`endif
);
    localparam int CW = WIDTH / STAGES;
    logic stall;
    assign stall    = out_valid && !out_ready;
    assign in_ready = !stall;
    for (genvar k = 0; k < STAGES; k++) begin : g_st
        localparam int RW = WIDTH - k * CW;
        localparam int SW = (k + 1) * CW;
        logic [RW-1:0] a_i, b_i;
        logic          c_i, v_i;
        logic [CW:0]   add;
        logic [SW-1:0] s_n, s_q;
        logic          c_q, v_q;
        if (k == 0) begin : g_head
            assign a_i = A;
            assign b_i = B;
            assign c_i = CIN;
            assign v_i = in_valid && in_ready;
            assign s_n = add[CW-1:0];
        end else begin : g_body
            assign a_i = g_st[k-1].g_fw.a_q;
            assign b_i = g_st[k-1].g_fw.b_q;
            assign c_i = g_st[k-1].c_q;
            assign v_i = g_st[k-1].v_q;
            assign s_n = {add[CW-1:0], g_st[k-1].s_q};
        end
        assign add = {1'b0, a_i[CW-1:0]} + {1'b0, b_i[CW-1:0]} + {{CW{1'b0}}, c_i};
        // Register this stage's partial sum, carry and valid; everything holds on stall
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                s_q <= '0;
                c_q <= 1'b0;
                v_q <= 1'b0;
            end else if (!stall) begin
                s_q <= s_n;
                c_q <= add[CW];
                v_q <= v_i;
            end
        end
        if (k < STAGES - 1) begin : g_fw
            logic [RW-CW-1:0] a_q, b_q;
            // Skew the not-yet-added operand chunks forward to the next stage
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (!stall) begin
                    a_q <= a_i[RW-1:CW];
                    b_q <= b_i[RW-1:CW];
                end
            end
        end
    end
    assign out_valid = g_st[STAGES-1].v_q;
    assign SUM       = g_st[STAGES-1].s_q;
    assign COUT      = g_st[STAGES-1].c_q;
`ifdef PIPE_ADDER_OVF_EN
    logic ovf_q;
    // Signed overflow from the top chunk's sign bits, registered alongside the final sum
    always_ff @(posedge clk) begin
        if (!rst_n)
            ovf_q <= 1'b0;
        else if (!stall)
            ovf_q <= (g_st[STAGES-1].a_i[CW-1] == g_st[STAGES-1].b_i[CW-1]) &&
                     (g_st[STAGES-1].add[CW-1] != g_st[STAGES-1].a_i[CW-1]);
    end
    assign OVF = ovf_q && out_valid;
`endif
endmodule

// File: tb/tb_pipe_adder.sv
// tb_pipe_adder: scoreboard bench for pipe_adder (8-bit/2-stage streaming, 32-bit/4-stage directed)
module tb_pipe_adder;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic       rst_n, in_valid, in_ready, CIN, out_valid, out_ready, COUT;
    logic [7:0] A, B, SUM;
    logic        w_in_valid, w_in_ready, w_cin, w_out_valid, w_out_ready, w_cout;
    logic [31:0] w_a, w_b, w_sum;
`ifdef PIPE_ADDER_OVF_EN
    logic ovf, w_ovf;
`endif
    typedef struct packed { logic [7:0] sum; logic cout; logic ovf; } exp_t;
    typedef struct packed { logic [7:0] a, b; logic c; logic [7:0] s; logic co, ov; } vec_t;
    exp_t exp_q[$];
    exp_t e_m;
    logic [7:0] held;
    int checks = 0, failures = 0, outs = 0;
    vec_t vecs [8] = '{
        '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0},
        '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0},
        '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1},
        '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1},
        '{8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0},
        '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0},
        '{8'hC8, 8'h64, 1'b1, 8'h2D, 1'b1, 1'b0},
        '{8'h01, 8'hFE, 1'b0, 8'hFF, 1'b0, 1'b0}
    };

    pipe_adder #(.WIDTH(8), .STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .CIN(CIN), .out_valid(out_valid), .out_ready(out_ready),
        .SUM(SUM), .COUT(COUT)
`ifdef PIPE_ADDER_OVF_EN
        , .OVF(ovf)
`endif
    );

    pipe_adder #(.WIDTH(32), .STAGES(4)) dut_w (
        .clk(clk), .rst_n(rst_n), .in_valid(w_in_valid), .in_ready(w_in_ready),
        .A(w_a), .B(w_b), .CIN(w_cin), .out_valid(w_out_valid), .out_ready(w_out_ready),
        .SUM(w_sum), .COUT(w_cout)
`ifdef PIPE_ADDER_OVF_EN
        , .OVF(w_ovf)
`endif
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic c,
                        input logic [7:0] s, input logic co, input logic ov);
        bit ok = 1'b0;
        in_valid = 1'b1; A = a; B = b; CIN = c;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge clk);
            ok = in_ready;
            if (ok) exp_q.push_back('{s, co, ov});
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (!ok) chk("send_timeout", 64'd0, 64'd1);
    endtask

    task automatic drain(input string name);
        for (int n = 0; n < 50 && exp_q.size() != 0; n++) @(posedge clk);
        #1 chk(name, exp_q.size(), 64'd0);
    endtask

    task automatic wide(input logic [31:0] a, input logic [31:0] b, input logic c,
                        input logic [31:0] s, input logic co);
        w_in_valid = 1'b1; w_a = a; w_b = b; w_cin = c;
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk); #1;
            w_in_valid = 1'b0;
            chk("w_latency_valid", w_out_valid, i == 4);
        end
        chk("w_sum", w_sum, s);
        chk("w_cout", w_cout, co);
    endtask

    // Scoreboard monitor: pop and compare on every accepted output
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_output", out_valid, 1'b0);
            end else begin
                e_m = exp_q.pop_front();
                chk("sum", SUM, e_m.sum);
                chk("cout", COUT, e_m.cout);
`ifdef PIPE_ADDER_OVF_EN
                chk("ovf", ovf, e_m.ovf);
`endif
                outs++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; A = '0; B = '0; CIN = 1'b0; out_ready = 1'b1;
        w_in_valid = 1'b0; w_a = '0; w_b = '0; w_cin = 1'b0; w_out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_sum", SUM, 8'h00);
        chk("rst_cout", COUT, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_w_out_valid", w_out_valid, 1'b0);
        rst_n = 1'b1;
        send(8'h55, 8'hAA, 1'b1, 8'h00, 1'b1, 1'b0);
        chk("latency_1_valid", out_valid, 1'b0);
        @(posedge clk); #1;
        chk("latency_2_valid", out_valid, 1'b1);
        drain("drain_first");
        foreach (vecs[i]) send(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].s, vecs[i].co, vecs[i].ov);
        drain("drain_vectors");
        for (int i = 0; i < 256; i++) begin
            logic [7:0] a;
            logic [8:0] t;
            a = 8'(i);
            t = {1'b0, a} + 9'h0AA + {8'd0, a[0]};
            send(a, 8'hAA, a[0], t[7:0], t[8], a[7] & ~t[7]);
        end
        drain("drain_sweep");
        fork
            for (int i = 0; i < 12; i++)
                send(8'(i * 16 + 1), 8'h0F, 1'b0, 8'((i + 1) * 16), 1'b0, i == 7);
            begin
                repeat (4) @(posedge clk);
                #2 out_ready = 1'b0;
                held = SUM;
                chk("stall_out_valid", out_valid, 1'b1);
                for (int n = 0; n < 5; n++) begin
                    @(negedge clk);
                    chk("stall_in_ready", in_ready, 1'b0);
                    chk("stall_sum_hold", SUM, held);
                end
                @(posedge clk);
                #2 out_ready = 1'b1;
            end
        join
        drain("drain_stall");
        in_valid = 1'b1; A = 8'h11; B = 8'h22; CIN = 1'b0;
        @(posedge clk); #1;
        A = 8'h33;
        @(posedge clk); #1;
        in_valid = 1'b0; rst_n = 1'b0;
        exp_q.delete();
        @(posedge clk); #1;
        chk("reset_flush_valid", out_valid, 1'b0);
        rst_n = 1'b1;
        for (int n = 0; n < 4; n++) begin
            @(posedge clk); #1;
            chk("reset_no_stale", out_valid, 1'b0);
        end
        wide(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1);
        wide(32'h0001_FFFF, 32'h0000_FFFF, 1'b0, 32'h0002_FFFE, 1'b0);
        wide(32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1);
        chk("out_count", outs, 64'd277);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
